// File: rtl/refclk_strobe_gen_if.sv
// Reference-clock input and derived timekeeping strobes between the refclk pin and the time-set logic.
// The slave side (strobe generator) samples i_refclk and drives the sync observe signal and the three strobes.
interface refclk_strobe_gen_if;
    logic i_refclk;
    logic o_refclk_sync;
    logic o_1hz_stb;
    logic o_slow_set_stb;
    logic o_fast_set_stb;

    modport master (
        output i_refclk,
        input  o_refclk_sync,
        input  o_1hz_stb,
        input  o_slow_set_stb,
        input  o_fast_set_stb
    );

    modport slave (
        input  i_refclk,
        output o_refclk_sync,
        output o_1hz_stb,
        output o_slow_set_stb,
        output o_fast_set_stb
    );
endinterface

// File: rtl/refclk_strobe_gen.sv
// Syncs the async 32.768 kHz refclk, counts its rising edges, emits single-cycle 1 Hz / slow-set / fast-set strobes.
// Latency 3 i_clk edges from the first sample of refclk high to strobe; no backpressure, strobes are fire-and-forget.
module refclk_strobe_gen #(
    parameter int REFCLK_DIV_BITS = 15,
    parameter int SLOW_SET_BITS   = 14,
    parameter int FAST_SET_BITS   = 12
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    refclk_strobe_gen_if.slave strb
);
    localparam logic [REFCLK_DIV_BITS-1:0] CNT_ONE = REFCLK_DIV_BITS'(1);

    logic                       sync1;
    logic                       sync2;
    logic                       prev;
    logic                       ref_rise;
    logic [REFCLK_DIV_BITS-1:0] cnt;
    logic                       hz_stb_q;
    logic                       slow_stb_q;
    logic                       fast_stb_q;

    // Two-flop synchronizer; both stages clear on reset so release never looks like an edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= strb.i_refclk;
            sync2 <= sync1;
        end
    end

    assign ref_rise = sync2 & ~prev;

    // Strobes decode the count before it increments, so the Nth edge (cnt = N-1) fires the pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev       <= 1'b0;
            cnt        <= '0;
            hz_stb_q   <= 1'b0;
            slow_stb_q <= 1'b0;
            fast_stb_q <= 1'b0;
        end else begin
            prev       <= sync2;
            if (ref_rise) begin
                cnt <= cnt + CNT_ONE;
            end
            hz_stb_q   <= ref_rise & (&cnt);
            slow_stb_q <= ref_rise & (&cnt[SLOW_SET_BITS-1:0]);
            fast_stb_q <= ref_rise & (&cnt[FAST_SET_BITS-1:0]);
        end
    end

    assign strb.o_refclk_sync  = sync2;
    assign strb.o_1hz_stb      = hz_stb_q;
    assign strb.o_slow_set_stb = slow_stb_q;
    assign strb.o_fast_set_stb = fast_stb_q;
endmodule

// File: tb/tb_refclk_strobe_gen.sv
// Bench for refclk_strobe_gen with shrunk divider widths (same 1:2:8 strobe ratios) to keep the run short.
module tb_refclk_strobe_gen;
    localparam int R = 7;
    localparam int S = 6;
    localparam int F = 4;

    typedef struct {
        int         cyc;
        logic [2:0] vec;   // {1hz, slow, fast}
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset_n;

    refclk_strobe_gen_if sif ();

    refclk_strobe_gen #(
        .REFCLK_DIV_BITS(R),
        .SLOW_SET_BITS  (S),
        .FAST_SET_BITS  (F)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .strb     (sif)
    );

    always #5 i_clk = ~i_clk;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         model_cnt = 0;
    int         exp_hz = 0, exp_slow = 0, exp_fast = 0;
    int         obs_hz = 0, obs_slow = 0, obs_fast = 0;
    logic [2:0] mon_obs;
    logic [2:0] mon_exp;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every cycle the strobe vector must equal the scoreboard entry due now, or zero.
    always @(posedge i_clk) begin
        #1;
        mon_obs = {sif.o_1hz_stb, sif.o_slow_set_stb, sif.o_fast_set_stb};
        mon_exp = 3'b000;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_exp = sb[0].vec;
            void'(sb.pop_front());
        end
        chk("strobes", {29'd0, mon_obs}, {29'd0, mon_exp});
        if (i_reset_n) begin
            obs_hz   += int'(mon_obs[2]);
            obs_slow += int'(mon_obs[1]);
            obs_fast += int'(mon_obs[0]);
        end
    end

    task automatic drive_rise();
        exp_t e;
        @(negedge i_clk);
        sif.i_refclk = 1'b1;
        e.vec[0] = ((model_cnt % (1 << F)) == (1 << F) - 1);
        e.vec[1] = ((model_cnt % (1 << S)) == (1 << S) - 1);
        e.vec[2] = (model_cnt == (1 << R) - 1);
        e.cyc    = cyc + 3;
        if (e.vec != 3'b000) sb.push_back(e);
        exp_hz    += int'(e.vec[2]);
        exp_slow  += int'(e.vec[1]);
        exp_fast  += int'(e.vec[0]);
        model_cnt  = (model_cnt + 1) % (1 << R);
    endtask

    task automatic drive_fall();
        @(negedge i_clk);
        sif.i_refclk = 1'b0;
    endtask

    // Two cycles high, two cycles low.
    task automatic refclk_period();
        drive_rise();
        @(negedge i_clk);
        drive_fall();
        @(negedge i_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sync"}, {31'd0, sif.o_refclk_sync}, 32'd0);
        chk({tag, "_1hz"},  {31'd0, sif.o_1hz_stb}, 32'd0);
        chk({tag, "_slow"}, {31'd0, sif.o_slow_set_stb}, 32'd0);
        chk({tag, "_fast"}, {31'd0, sif.o_fast_set_stb}, 32'd0);
        chk({tag, "_cnt"},  32'(dut.cnt), 32'd0);
    endtask

    initial begin
        i_reset_n    = 1'b0;
        sif.i_refclk = 1'b0;

        // Reset held while refclk toggles.
        repeat (4) begin
            @(negedge i_clk);
            sif.i_refclk = ~sif.i_refclk;
        end
        @(negedge i_clk);
        chk_all_zero("reset");
        sif.i_refclk = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // First edge: synchronizer delay and counter step.
        drive_rise();
        @(negedge i_clk);
        chk("sync_after_1", {31'd0, sif.o_refclk_sync}, 32'd0);
        @(negedge i_clk);
        chk("sync_after_2", {31'd0, sif.o_refclk_sync}, 32'd1);
        sif.i_refclk = 1'b0;
        @(negedge i_clk);
        chk("sync_fall_1", {31'd0, sif.o_refclk_sync}, 32'd1);
        @(negedge i_clk);
        chk("sync_fall_2", {31'd0, sif.o_refclk_sync}, 32'd0);
        chk("cnt_first_edge", 32'(dut.cnt), 32'd1);

        // Two full 1 Hz intervals (edges 128 and 256).
        repeat (259) refclk_period();
        chk("cnt_after_260", 32'(dut.cnt), 32'(model_cnt));

        // Refclk held constant high, then low: counter frozen, no strobes.
        drive_rise();
        repeat (20) @(negedge i_clk);
        chk("hold_hi_sync", {31'd0, sif.o_refclk_sync}, 32'd1);
        chk("hold_hi_cnt", 32'(dut.cnt), 32'(model_cnt));
        drive_fall();
        repeat (20) @(negedge i_clk);
        chk("hold_lo_cnt", 32'(dut.cnt), 32'(model_cnt));

        // Run up to a fast-strobe edge, then reset while that strobe is high.
        while (model_cnt != 79) refclk_period();
        drive_rise();
        @(negedge i_clk);
        drive_fall();
        @(negedge i_clk);
        chk("fast_before_reset", {31'd0, sif.o_fast_set_stb}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        sb.delete();
        model_cnt = 0;
        #1;
        chk_all_zero("midreset");
        repeat (2) begin
            @(negedge i_clk);
            sif.i_refclk = ~sif.i_refclk;
        end
        sif.i_refclk = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Restart from zero: next 1 Hz strobe only on the 128th edge after release.
        repeat (130) refclk_period();
        repeat (8) @(negedge i_clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("hz_total", 32'(obs_hz), 32'd3);
        chk("hz_model", 32'(obs_hz), 32'(exp_hz));
        chk("slow_total", 32'(obs_slow), 32'(exp_slow));
        chk("fast_total", 32'(obs_fast), 32'(exp_fast));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/refclk_strobe_gen.md
Name: refclk_strobe_gen

Overview:
- Generates timekeeping strobes for the 7-segment clock from an asynchronous 32.768 kHz reference (watch crystal) input.
- Synchronizes the reference into the system clock domain and detects its rising edges.
- Divides the edge count into three single-cycle strobes: 1 Hz timekeeping, a slow time-set rate and a fast time-set rate.
- Sits between the refclk input pin and the clock/time-set logic.

Parameters:
- REFCLK_DIV_BITS, 15: counter width; the 1 Hz strobe fires every 2^15 = 32768 refclk rising edges.
- SLOW_SET_BITS, 14: the slow-set strobe fires every 2^14 edges (2 Hz at 32.768 kHz).
- FAST_SET_BITS, 12: the fast-set strobe fires every 2^12 edges (8 Hz at 32.768 kHz).
- Constraint: FAST_SET_BITS <= SLOW_SET_BITS <= REFCLK_DIV_BITS.

Ports:
- i_clk, input, 1: system clock; all logic is in this domain.
- i_reset_n, input, 1: reset, asynchronous, active-low.
- i_refclk, input, 1: asynchronous reference clock (nominally 32.768 kHz).
- o_refclk_sync, output, 1: i_refclk after the 2-flop synchronizer (debug/observe).
- o_1hz_stb, output, 1: one-i_clk-cycle pulse every 2^REFCLK_DIV_BITS refclk rising edges.
- o_slow_set_stb, output, 1: one-cycle pulse every 2^SLOW_SET_BITS refclk rising edges.
- o_fast_set_stb, output, 1: one-cycle pulse every 2^FAST_SET_BITS refclk rising edges.

Behaviour:
- Clock and reset: one clock, i_clk. i_reset_n is asynchronous, active-low. While low, every flop is cleared: synchronizer stages, edge-history flop, counter and all three strobes, so every output is 0. Logic runs from the first i_clk rising edge after release.
- Synchronizer: sync1 <= i_refclk; sync2 <= sync1. o_refclk_sync = sync2.
- Edge detect: prev <= sync2; edge = sync2 & ~prev (combinational).
  - Exactly one edge pulse per refclk rising edge.
  - No edge is produced by the reset release itself, since all stages reset to 0.
  - Falling edges are ignored.
- Counter:
  - REFCLK_DIV_BITS-bit cnt, increments by 1 on each cycle where edge = 1 and holds otherwise.
  - Wraps from all-ones to 0 naturally; no saturation.
- Strobes (registered):
  - o_1hz_stb <= edge & (cnt == all ones).
  - o_slow_set_stb <= edge & (cnt[SLOW_SET_BITS-1:0] == all ones).
  - o_fast_set_stb <= edge & (cnt[FAST_SET_BITS-1:0] == all ones).
  - Each strobe is high for exactly one i_clk cycle, then returns to 0.
- Latency: the refclk rising edge is sampled into sync1, then sync2 (edge asserted), then the strobe register. The strobe is visible 3 i_clk edges after the sampling edge where i_refclk was first seen high.
- Simultaneous strobes: at the 1 Hz terminal count, the slow and fast strobes also fire in the same cycle, since the lower bits are all ones. Likewise fast fires whenever slow fires.
- First strobes after reset:
  - o_fast_set_stb on the 4096th refclk rising edge.
  - o_slow_set_stb on the 16384th.
  - o_1hz_stb on the 32768th.
  - Then periodically with those spacings.
- Frequency requirement: each refclk high and low phase must last at least 2 i_clk periods. Nominal: i_clk 12.5 MHz (80 ns) against refclk ≥ 30.5 µs period; faster refclk in simulation is permitted.
- Reset mid-operation: counter returns to 0 immediately. Any in-flight strobe is cleared. Counting restarts from 0 after release; no strobe is emitted for the partial interval.
- Target size: 120–200 lines of RTL. The synchronizer may be a separate submodule internal to this block.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with refclk toggling -> all outputs 0, cnt 0. Release -> no strobe before the 4096th refclk rising edge.
- Fast strobe: i_clk 80 ns, refclk period 3051 ns -> o_fast_set_stb pulses 1 cycle wide, spaced exactly 4096 refclk edges apart. First pulse occurs 3 i_clk edges after the 4096th refclk rise is sampled.
- Slow and 1 Hz: run to 2 o_1hz_stb pulses -> o_1hz_stb spaced exactly 32768 refclk edges apart. o_slow_set_stb occurs 2 times per 1 Hz interval, o_fast_set_stb 8 times. All three coincide on the 1 Hz cycle.
- Pulse width: check every strobe -> high exactly 1 i_clk cycle, never 2 consecutive cycles.
- Synchronizer: refclk toggle -> o_refclk_sync follows after 2 i_clk edges. Refclk held constant -> no strobes and cnt frozen.
- Mid-run reset: assert i_reset_n=0 after 20000 edges -> outputs drop to 0 asynchronously. After release, first o_1hz_stb only after another 32768 edges.
